// File: rtl/smart_home_pkg.sv
// Shared types for the home service sequencer: service codes, grant priority
// order, actuator drive payload and the helpers that decode and arbitrate them.
package smart_home_pkg;

  localparam int unsigned TEMP_W  = 7;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned NUM_SRV = 6;

  typedef enum logic [CODE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FDOOR  = 3'd1,
    ST_RDOOR  = 3'd2,
    ST_ALARM  = 3'd3,
    ST_WINDOW = 3'd4,
    ST_HEAT   = 3'd5,
    ST_COOL   = 3'd6
  } state_e;

  localparam state_e PRIO_ORDER [NUM_SRV] = '{ST_ALARM, ST_FDOOR, ST_RDOOR,
                                              ST_WINDOW, ST_COOL, ST_HEAT};

  typedef struct packed {
    logic              fdoor;
    logic              rdoor;
    logic              winbuzz;
    logic              alarmbuzz;
    logic              heater;
    logic              cooler;
    logic [CODE_W-1:0] display;
  } drive_t;

  // One-hot actuator drive plus panel code; unused code 3'b111 decodes to all-off.
  function automatic drive_t decode_drive(input state_e s);
    drive_t d;
    d = '0;
    case (s)
      ST_FDOOR:  begin d.fdoor     = 1'b1; d.display = ST_FDOOR;  end
      ST_RDOOR:  begin d.rdoor     = 1'b1; d.display = ST_RDOOR;  end
      ST_ALARM:  begin d.alarmbuzz = 1'b1; d.display = ST_ALARM;  end
      ST_WINDOW: begin d.winbuzz   = 1'b1; d.display = ST_WINDOW; end
      ST_HEAT:   begin d.heater    = 1'b1; d.display = ST_HEAT;   end
      ST_COOL:   begin d.cooler    = 1'b1; d.display = ST_COOL;   end
      default:   d = '0;
    endcase
    return d;
  endfunction

  // Highest-priority pending request, skipping the service being released.
  function automatic state_e pick_next(input logic [7:0] req, input state_e excl);
    state_e nxt;
    nxt = ST_IDLE;
    for (int i = int'(NUM_SRV) - 1; i >= 0; i--) begin
      if (req[PRIO_ORDER[i]] && (PRIO_ORDER[i] != excl)) nxt = PRIO_ORDER[i];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level only
// follows the input after DEB_CYCLES consecutive cycles of the new value.
module sensor_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic Rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      // Any cycle agreeing with the current level restarts the stability count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/home_service_sequencer.sv
// Debounces door/window/fire sensors, applies temperature hysteresis and grants
// one actuator service at a time with a minimum dwell and fair hand-off.
module home_service_sequencer
  import smart_home_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned T_LOW       = 18,
  parameter int unsigned T_HIGH      = 30,
  parameter int unsigned HYST        = 2
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic              SFD,
  input  logic              SRD,
  input  logic              SW,
  input  logic              SFA,
  input  logic [TEMP_W-1:0] ST,
  output logic              fdoor,
  output logic              rdoor,
  output logic              winbuzz,
  output logic              alarmbuzz,
  output logic              heater,
  output logic              cooler,
  output logic [CODE_W-1:0] display
);

  localparam int unsigned DWELL_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] HOLD_LOAD = DWELL_W'(HOLD_CYCLES - 1);
  localparam logic [TEMP_W-1:0]  HEAT_ON   = TEMP_W'(T_LOW);
  localparam logic [TEMP_W-1:0]  HEAT_OFF  = TEMP_W'(T_LOW + HYST);
  localparam logic [TEMP_W-1:0]  COOL_ON   = TEMP_W'(T_HIGH);
  localparam logic [TEMP_W-1:0]  COOL_OFF  = TEMP_W'(T_HIGH - HYST);

  if (DEB_CYCLES < 2 || HOLD_CYCLES < 2 || (T_LOW + 2 * HYST) > T_HIGH) begin : g_param_err
    $error("home_service_sequencer: illegal DEB_CYCLES/HOLD_CYCLES/T_LOW/T_HIGH/HYST");
  end

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_sync_n = rst_sync_q[1];

  // Sensor index: 0 front door, 1 rear door, 2 window, 3 fire.
  logic [3:0] raw_vec;
  logic [3:0] lvl;

  assign raw_vec = {SFA, SW, SRD, SFD};

  for (genvar g = 0; g < 4; g++) begin : g_deb
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .Rst_n (rst_sync_n),
      .raw   (raw_vec[g]),
      .level (lvl[g])
    );
  end

  // Temperature hysteresis; flags only evaluate once a real sample is held.
  logic [TEMP_W-1:0] st_q;
  logic              st_valid_q;
  logic              need_heat_q, need_cool_q;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      st_q        <= '0;
      st_valid_q  <= 1'b0;
      need_heat_q <= 1'b0;
      need_cool_q <= 1'b0;
    end else begin
      st_q       <= ST;
      st_valid_q <= 1'b1;
      if (st_valid_q) begin
        if (need_heat_q) begin
          if (st_q >= HEAT_OFF) need_heat_q <= 1'b0;
        end else if (st_q < HEAT_ON) begin
          need_heat_q <= 1'b1;
        end
        if (need_cool_q) begin
          if (st_q <= COOL_OFF) need_cool_q <= 1'b0;
        end else if (st_q > COOL_ON) begin
          need_cool_q <= 1'b1;
        end
      end
    end
  end

  // Request vector indexed by service code.
  logic [7:0] req;
  assign req = {1'b0, need_cool_q, need_heat_q, lvl[2], lvl[3], lvl[1], lvl[0], 1'b0};

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  drive_t             drive_q;
  logic               own_req, others_req;

  // ALARM releases only once the fire input drops, so it is never handed off while active.
  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    own_req    = req[state_q];
    others_req = |(req & ~(8'd1 << state_q));
    case (state_q)
      ST_IDLE: begin
        state_d = pick_next(req, ST_IDLE);
        if (state_d != ST_IDLE) dwell_d = HOLD_LOAD;
      end
      ST_FDOOR, ST_RDOOR, ST_ALARM, ST_WINDOW, ST_HEAT, ST_COOL: begin
        if (req[ST_ALARM] && (state_q != ST_ALARM)) begin
          state_d = ST_ALARM;
          dwell_d = HOLD_LOAD;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else if (!own_req || (others_req && (state_q != ST_ALARM))) begin
          state_d = pick_next(req, state_q);
          dwell_d = (state_d == ST_IDLE) ? '0 : HOLD_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dwell_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      drive_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      drive_q <= decode_drive(state_q);
    end
  end

  assign fdoor     = drive_q.fdoor;
  assign rdoor     = drive_q.rdoor;
  assign winbuzz   = drive_q.winbuzz;
  assign alarmbuzz = drive_q.alarmbuzz;
  assign heater    = drive_q.heater;
  assign cooler    = drive_q.cooler;
  assign display   = drive_q.display;

endmodule

// File: tb/tb_home_service_sequencer.sv
// Bench for home_service_sequencer: directed scenarios plus random sensor and
// temperature traffic, every cycle compared against a behavioural model.
module tb_home_service_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int TL   = 18;
  localparam int TH   = 30;
  localparam int HY   = 2;

  localparam logic [8:0] V_IDLE   = 9'b0_0000_0_000;
  localparam logic [8:0] V_FDOOR  = {1'b1, 5'b00000, 3'b001};
  localparam logic [8:0] V_RDOOR  = {1'b0, 1'b1, 4'b0000, 3'b010};
  localparam logic [8:0] V_WINDOW = {2'b00, 1'b1, 3'b000, 3'b100};
  localparam logic [8:0] V_ALARM  = {3'b000, 1'b1, 2'b00, 3'b011};
  localparam logic [8:0] V_HEAT   = {4'b0000, 1'b1, 1'b0, 3'b101};
  localparam logic [8:0] V_COOL   = {5'b00000, 1'b1, 3'b110};

  logic       clk, Rst_n, SFD, SRD, SW, SFA;
  logic [6:0] ST;
  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
  logic [2:0] display;

  int n_cmp = 0;
  int n_err = 0;

  home_service_sequencer #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .T_LOW(TL), .T_HIGH(TH), .HYST(HY)
  ) dut (
    .clk(clk), .Rst_n(Rst_n), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz), .alarmbuzz(alarmbuzz),
    .heater(heater), .cooler(cooler), .display(display)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, display};
  endfunction

  // ---------------- behavioural reference model ----------------
  int          m_rel;        // edges seen since Rst_n released
  logic [15:0] m_raw[4];     // raw samples, newest in bit 0
  logic [15:0] m_syn[4];     // synchronised samples seen by the debouncer
  logic [3:0]  m_lvl;
  bit          m_heat, m_cool, m_st_seen;
  int          m_st, m_state, m_age, m_out;
  int          prio[6] = '{3, 1, 2, 4, 6, 5};

  function automatic logic [8:0] exp_vec(input int code);
    logic [8:0] v;
    v = '0;
    case (code)
      1: v[8] = 1'b1;
      2: v[7] = 1'b1;
      4: v[6] = 1'b1;
      3: v[5] = 1'b1;
      5: v[4] = 1'b1;
      6: v[3] = 1'b1;
      default: ;
    endcase
    v[2:0] = code[2:0];
    return v;
  endfunction

  function automatic int m_pick(input logic [7:0] rq, input int excl);
    for (int i = 0; i < 6; i++) if (rq[prio[i]] && prio[i] != excl) return prio[i];
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_raw[s] = '0;
      m_syn[s] = '0;
    end
    m_lvl = '0; m_heat = 0; m_cool = 0; m_st_seen = 0;
    m_st = 0; m_state = 0; m_age = 0; m_out = 0;
  endtask

  task automatic model_edge();
    logic [7:0] rq;
    logic [3:0] raw;
    logic       obs;
    int         ns, nage;
    bit         others, leave;
    if (!Rst_n) begin
      m_rel = 0;
      model_reset();
      return;
    end
    m_rel++;
    if (m_rel <= 2) begin
      model_reset();
      return;
    end
    rq = '0;
    rq[1] = m_lvl[0]; rq[2] = m_lvl[1]; rq[3] = m_lvl[3];
    rq[4] = m_lvl[2]; rq[5] = m_heat;   rq[6] = m_cool;
    ns = m_state; nage = m_age;
    if (m_state == 0) begin
      ns = m_pick(rq, 0); nage = 0;
    end else if (rq[3] && m_state != 3) begin
      ns = 3; nage = 0;
    end else if (m_age < HOLD - 1) begin
      nage = m_age + 1;
    end else begin
      others = 0;
      for (int c = 1; c < 7; c++) if (c != m_state && rq[c]) others = 1;
      leave = (m_state == 3) ? !rq[3] : (!rq[m_state] || others);
      if (leave) begin
        ns = m_pick(rq, m_state); nage = 0;
      end
    end
    raw = {SFA, SW, SRD, SFD};
    for (int s = 0; s < 4; s++) begin
      obs = m_raw[s][1];
      m_raw[s] = {m_raw[s][14:0], raw[s]};
      m_syn[s] = {m_syn[s][14:0], obs};
      if (m_syn[s][DEB-1:0] == {DEB{~m_lvl[s]}}) m_lvl[s] = ~m_lvl[s];
    end
    if (m_st_seen) begin
      m_heat = m_heat ? !(m_st >= TL + HY) : (m_st < TL);
      m_cool = m_cool ? !(m_st <= TH - HY) : (m_st > TH);
    end
    m_st = int'(ST); m_st_seen = 1;
    m_out = m_state; m_state = ns; m_age = nage;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle_drive", 32'(dut_vec()), 32'(exp_vec(m_out)));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] rnd_raw;
  int         hold[4];

  initial begin
    Rst_n = 1'b0; SFD = 0; SRD = 0; SW = 0; SFA = 0; ST = 7'd25;
    m_rel = 0;
    model_reset();
    repeat (3) tick();
    chk("reset_state", 32'(dut_vec()), 32'(V_IDLE));
    Rst_n = 1'b1;
    repeat (6) tick();
    chk("idle_after_reset", 32'(dut_vec()), 32'(V_IDLE));

    // front door: latency, dwell, release
    SFD = 1;
    repeat (7) tick();
    chk("fdoor_pre_latency", 32'(dut_vec()), 32'(V_IDLE));
    tick();
    chk("fdoor_latency", 32'(dut_vec()), 32'(V_FDOOR));
    repeat (2) tick();
    SFD = 0;
    repeat (5) tick();
    chk("fdoor_dwell", 32'(dut_vec()), 32'(V_FDOOR));
    for (int i = 0; i < 40 && fdoor; i++) tick();
    chk("fdoor_release", 32'(dut_vec()), 32'(V_IDLE));

    // window glitch then held
    SW = 1; repeat (3) tick(); SW = 0;
    repeat (12) tick();
    chk("sw_glitch", 32'(dut_vec()), 32'(V_IDLE));
    SW = 1; repeat (8) tick();
    chk("sw_held", 32'(dut_vec()), 32'(V_WINDOW));
    SW = 0; repeat (24) tick();
    chk("sw_idle", 32'(dut_vec()), 32'(V_IDLE));

    // temperature hysteresis
    ST = 7'd17; repeat (4) tick();
    chk("heat_on", 32'(dut_vec()), 32'(V_HEAT));
    ST = 7'd19; repeat (10) tick();
    chk("heat_band", 32'(dut_vec()), 32'(V_HEAT));
    ST = 7'd20; repeat (3) tick();
    chk("heat_last", 32'(dut_vec()), 32'(V_HEAT));
    tick();
    chk("heat_off", 32'(dut_vec()), 32'(V_IDLE));
    ST = 7'd31; repeat (4) tick();
    chk("cool_on", 32'(dut_vec()), 32'(V_COOL));
    repeat (10) tick();
    ST = 7'd29; repeat (4) tick();
    chk("cool_band", 32'(dut_vec()), 32'(V_COOL));
    ST = 7'd28; repeat (4) tick();
    chk("cool_off", 32'(dut_vec()), 32'(V_IDLE));
    ST = 7'd18; repeat (6) tick();
    chk("heat_threshold", 32'(dut_vec()), 32'(V_IDLE));
    ST = 7'd25; repeat (4) tick();

    // fire preempts rear door
    SRD = 1; repeat (8) tick();
    chk("rdoor_on", 32'(dut_vec()), 32'(V_RDOOR));
    repeat (3) tick();
    SFA = 1;
    for (int i = 0; i < 20 && !alarmbuzz; i++) tick();
    chk("alarm_preempt", 32'(dut_vec()), 32'(V_ALARM));
    repeat (4) tick();
    SFA = 0; repeat (3) tick();
    chk("alarm_hold", 32'(dut_vec()), 32'(V_ALARM));
    for (int i = 0; i < 30 && !rdoor; i++) tick();
    chk("rdoor_resume", 32'(dut_vec()), 32'(V_RDOOR));
    SRD = 0; repeat (24) tick();
    chk("rdoor_idle", 32'(dut_vec()), 32'(V_IDLE));

    // both doors: fair hand-off
    SFD = 1; SRD = 1;
    repeat (8) tick();
    chk("pair_fdoor", 32'(dut_vec()), 32'(V_FDOOR));
    repeat (7) tick();
    chk("pair_fdoor_dwell", 32'(dut_vec()), 32'(V_FDOOR));
    tick();
    chk("pair_handoff", 32'(dut_vec()), 32'(V_RDOOR));
    repeat (8) tick();
    chk("pair_resume", 32'(dut_vec()), 32'(V_FDOOR));
    SFD = 0; SRD = 0; repeat (30) tick();
    chk("pair_idle", 32'(dut_vec()), 32'(V_IDLE));

    // reset in the middle of cooling
    ST = 7'd31;
    for (int i = 0; i < 12 && !cooler; i++) tick();
    chk("cool_before_reset", 32'(dut_vec()), 32'(V_COOL));
    Rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(dut_vec()), 32'(V_IDLE));
    SFD = 1; ST = 7'd25;
    repeat (2) tick();
    Rst_n = 1'b1;
    repeat (9) tick();
    chk("redebounce_pre", 32'(dut_vec()), 32'(V_IDLE));
    tick();
    chk("redebounce", 32'(dut_vec()), 32'(V_FDOOR));
    SFD = 0; repeat (24) tick();

    // random traffic
    rnd_raw = '0;
    for (int s = 0; s < 4; s++) hold[s] = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int s = 0; s < 4; s++) begin
        hold[s]--;
        if (hold[s] <= 0) begin
          rnd_raw[s] = ~rnd_raw[s];
          if (s == 3) hold[s] = rnd_raw[s] ? int'($urandom_range(1, 20)) : int'($urandom_range(40, 200));
          else        hold[s] = int'($urandom_range(1, 14));
        end
      end
      SFD = rnd_raw[0]; SRD = rnd_raw[1]; SW = rnd_raw[2]; SFA = rnd_raw[3];
      if ($urandom_range(0, 49) == 0) ST = 7'($urandom_range(12, 36));
      Rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    Rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
